// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiplier stream driver: FSM states, beat/column counts
// derived from the matrix dimension, and the element-slice helper used for packing and unpacking.
package mm_pkg;

  localparam int unsigned NumElements = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StCollect,
    StDone
  } mm_state_e;

  // Each beat carries two rows of one column of both A and B.
  function automatic int unsigned beat_count(input int unsigned mw);
    return (mw * mw) / 2;
  endfunction

  function automatic int unsigned col_count(input int unsigned mw);
    return mw;
  endfunction

  // Element 0 occupies the most-significant slot of a beat.
  function automatic int unsigned elem_lsb(input int unsigned width, input int unsigned idx);
    return (NumElements - 1 - idx) * width;
  endfunction

endpackage

// File: rtl/mm_operand_store.sv
// A/B operand register file with an element write port and a beat-addressed packed read port.
module mm_operand_store
  import mm_pkg::*;
#(
  parameter int unsigned Width       = 8,
  parameter int unsigned MatrixWidth = 4,
  localparam int unsigned IdxW       = $clog2(MatrixWidth),
  localparam int unsigned BeatW      = $clog2(beat_count(MatrixWidth))
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wr_en_i,
  input  logic                         wr_sel_i,
  input  logic [IdxW-1:0]              wr_row_i,
  input  logic [IdxW-1:0]              wr_col_i,
  input  logic [Width-1:0]             wr_data_i,
  input  logic [BeatW-1:0]             beat_i,
  output logic [NumElements*Width-1:0] beat_data_o
);

  localparam int unsigned Half = MatrixWidth / 2;

  logic [Width-1:0] a_q [MatrixWidth][MatrixWidth];
  logic [Width-1:0] b_q [MatrixWidth][MatrixWidth];

  logic [IdxW-1:0] row;
  logic [IdxW-1:0] row_nxt;
  logic [IdxW-1:0] col;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < MatrixWidth; r++) begin
        for (int c = 0; c < MatrixWidth; c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
        end
      end
    end else if (wr_en_i) begin
      if (wr_sel_i) begin
        b_q[wr_row_i][wr_col_i] <= wr_data_i;
      end else begin
        a_q[wr_row_i][wr_col_i] <= wr_data_i;
      end
    end
  end

  assign row     = IdxW'(2 * (int'(beat_i) % Half));
  assign col     = IdxW'(int'(beat_i) / Half);
  assign row_nxt = row + IdxW'(1);

  always_comb begin
    beat_data_o = '0;
    beat_data_o[elem_lsb(Width, 0) +: Width] = a_q[row][col];
    beat_data_o[elem_lsb(Width, 1) +: Width] = a_q[row_nxt][col];
    beat_data_o[elem_lsb(Width, 2) +: Width] = b_q[row][col];
    beat_data_o[elem_lsb(Width, 3) +: Width] = b_q[row_nxt][col];
  end

endmodule

// File: rtl/mm_stream_driver.sv
// Host-side driver: streams packed A/B operand beats to the multiplier, then collects result
// columns into a buffer readable by element index.
module mm_stream_driver
  import mm_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned NUM_ELEMENTS = 4,
  parameter int unsigned MATRIX_WIDTH = 4,
  localparam int unsigned IdxW        = $clog2(MATRIX_WIDTH)
) (
  input  logic                          w_clk,
  input  logic                          w_reset,
  input  logic                          ld_en,
  input  logic                          ld_sel,
  input  logic [IdxW-1:0]               ld_row,
  input  logic [IdxW-1:0]               ld_col,
  input  logic [WIDTH-1:0]              ld_data,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_ELEMENTS*WIDTH-1:0] wdata,
  output logic                          w_en,
  input  logic                          w_ready,
  output logic                          r_en,
  input  logic [NUM_ELEMENTS*WIDTH-1:0] Res,
  input  logic                          r_ready,
  input  logic [IdxW-1:0]               rd_row,
  input  logic [IdxW-1:0]               rd_col,
  output logic [WIDTH-1:0]              rd_data
);

  localparam int unsigned BeatCount = beat_count(MATRIX_WIDTH);
  localparam int unsigned ColCount  = col_count(MATRIX_WIDTH);
  localparam int unsigned BeatW     = $clog2(BeatCount);

  mm_state_e        state_q;
  logic [BeatW-1:0] beat_q;
  logic [IdxW-1:0]  col_q;
  logic             w_en_q;
  logic             r_en_q;
  logic             busy_q;
  logic             done_q;

  logic [NUM_ELEMENTS*WIDTH-1:0] beat_data;
  logic [WIDTH-1:0]              res_q [MATRIX_WIDTH][MATRIX_WIDTH];

  mm_operand_store #(
    .Width       (WIDTH),
    .MatrixWidth (MATRIX_WIDTH)
  ) u_operand_store (
    .clk_i       (w_clk),
    .rst_i       (w_reset),
    .wr_en_i     (ld_en),
    .wr_sel_i    (ld_sel),
    .wr_row_i    (ld_row),
    .wr_col_i    (ld_col),
    .wr_data_i   (ld_data),
    .beat_i      (beat_q),
    .beat_data_o (beat_data)
  );

  always_ff @(posedge w_clk) begin
    if (w_reset) begin
      state_q <= StIdle;
      beat_q  <= '0;
      col_q   <= '0;
      w_en_q  <= 1'b0;
      r_en_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StSend;
            beat_q  <= '0;
            col_q   <= '0;
            w_en_q  <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        StSend: begin
          // w_en is high for the whole of SEND, so w_ready alone marks a transfer.
          if (w_ready) begin
            if (beat_q == BeatW'(BeatCount - 1)) begin
              state_q <= StCollect;
              w_en_q  <= 1'b0;
              r_en_q  <= 1'b1;
            end else begin
              beat_q <= beat_q + BeatW'(1);
            end
          end
        end
        StCollect: begin
          if (r_ready) begin
            if (col_q == IdxW'(ColCount - 1)) begin
              state_q <= StDone;
              r_en_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              col_q <= col_q + IdxW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_reset) begin
      for (int r = 0; r < MATRIX_WIDTH; r++) begin
        for (int c = 0; c < MATRIX_WIDTH; c++) begin
          res_q[r][c] <= '0;
        end
      end
    end else if (state_q == StCollect && r_ready) begin
      for (int r = 0; r < MATRIX_WIDTH; r++) begin
        res_q[r][col_q] <= Res[elem_lsb(WIDTH, r) +: WIDTH];
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign w_en    = w_en_q;
  assign r_en    = r_en_q;
  assign wdata   = w_en_q ? beat_data : '0;
  assign rd_data = res_q[rd_row][rd_col];

endmodule

// File: tb/tb_mm_stream_driver.sv
// Scoreboard bench for mm_stream_driver: expected beats are queued by the stimulus and checked
// by a negedge monitor whenever the driver presents a beat.
module tb_mm_stream_driver;

  logic        w_clk;
  logic        w_reset;
  logic        ld_en;
  logic        ld_sel;
  logic [1:0]  ld_row;
  logic [1:0]  ld_col;
  logic [7:0]  ld_data;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] wdata;
  logic        w_en;
  logic        w_ready;
  logic        r_en;
  logic [31:0] Res;
  logic        r_ready;
  logic [1:0]  rd_row;
  logic [1:0]  rd_col;
  logic [7:0]  rd_data;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  int unsigned wen_cnt    = 0;
  int unsigned done_cnt   = 0;
  logic [31:0] exp_q [$];

  // Beats for A = identity, B[i][j] = 4i+j+1, worked out by hand.
  logic [31:0] beats1 [8] = '{32'h01000105, 32'h0000090D, 32'h00010206, 32'h00000A0E,
                              32'h00000307, 32'h01000B0F, 32'h00000408, 32'h00010C10};
  logic [31:0] beats4 [8] = '{32'h7F000000, 32'h00000000, 32'h00000000, 32'h00000000,
                              32'h00000000, 32'h00000000, 32'h00000000, 32'h00000055};

  mm_stream_driver #(
    .WIDTH        (8),
    .NUM_ELEMENTS (4),
    .MATRIX_WIDTH (4)
  ) dut (
    .w_clk   (w_clk),
    .w_reset (w_reset),
    .ld_en   (ld_en),
    .ld_sel  (ld_sel),
    .ld_row  (ld_row),
    .ld_col  (ld_col),
    .ld_data (ld_data),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .wdata   (wdata),
    .w_en    (w_en),
    .w_ready (w_ready),
    .r_en    (r_en),
    .Res     (Res),
    .r_ready (r_ready),
    .rd_row  (rd_row),
    .rd_col  (rd_col),
    .rd_data (rd_data)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Monitor: a beat presented with w_ready transfers; a stalled beat must match the head.
  always @(negedge w_clk) begin
    if (!w_reset && w_en) begin
      wen_cnt++;
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL beat_unexpected: got wdata %h, want no beat", wdata);
      end else if (w_ready) begin
        check("beat", wdata, exp_q.pop_front());
      end else begin
        check("beat_stall", wdata, exp_q[0]);
      end
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic load(input logic sel, input int r, input int c, input logic [7:0] d);
    ld_en = 1'b1; ld_sel = sel; ld_row = 2'(r); ld_col = 2'(c); ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic capture(input logic [31:0] col_data);
    r_ready = 1'b1; Res = col_data;
    tick();
    r_ready = 1'b0; Res = '0;
  endtask

  task automatic chk_rd(input string name, input int r, input int c, input logic [7:0] exp);
    rd_row = 2'(r); rd_col = 2'(c);
    #1;
    check(name, {24'h0, rd_data}, {24'h0, exp});
  endtask

  task automatic wait_r_en(input int budget);
    int n = 0;
    while (!r_en && n < budget) begin
      tick();
      n++;
    end
    check("collect_reached", {31'h0, r_en}, 32'h1);
  endtask

  initial begin
    w_reset = 1'b1; ld_en = 1'b0; ld_sel = 1'b0; ld_row = '0; ld_col = '0; ld_data = '0;
    start = 1'b0; w_ready = 1'b0; Res = '0; r_ready = 1'b0; rd_row = '0; rd_col = '0;
    tick(); tick();
    w_reset = 1'b0;
    check("rst_w_en", {31'h0, w_en}, 32'h0);
    check("rst_r_en", {31'h0, r_en}, 32'h0);
    check("rst_busy_done", {30'h0, busy, done}, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    chk_rd("rst_rd", 1, 2, 8'h00);

    // Test 1: identity x counting matrix, w_ready held high.
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        load(1'b0, i, j, (i == j) ? 8'h01 : 8'h00);
        load(1'b1, i, j, 8'(4 * i + j + 1));
      end
    end
    foreach (beats1[k]) exp_q.push_back(beats1[k]);
    wen_cnt = 0; done_cnt = 0; w_ready = 1'b1;
    pulse_start();
    check("send_busy", {31'h0, busy}, 32'h1);
    wait_r_en(50);
    check("w_en_cycles", wen_cnt, 32'd8);
    check("t1_beats_left", exp_q.size(), 32'd0);
    check("collect_w_en", {31'h0, w_en}, 32'h0);
    capture(32'h0A0B0C0D);
    tick();
    capture(32'h11121314);
    capture(32'h21222324);
    check("pre_done", {30'h0, busy, done}, 32'h2);
    capture(32'h31323334);
    check("done_pulse", {30'h0, busy, done}, 32'h1);
    check("done_r_en", {31'h0, r_en}, 32'h0);
    tick();
    check("done_cleared", {31'h0, done}, 32'h0);
    check("done_count", done_cnt, 32'd1);
    chk_rd("c00", 0, 0, 8'h0A);
    chk_rd("c30", 3, 0, 8'h0D);
    chk_rd("c12", 1, 2, 8'h22);
    chk_rd("c23", 2, 3, 8'h33);
    // r_ready in IDLE must be ignored.
    r_ready = 1'b1; Res = 32'hFFFFFFFF;
    tick(); tick();
    r_ready = 1'b0;
    chk_rd("idle_rready_c00", 0, 0, 8'h0A);

    // Test 2: w_ready toggling, with stray r_ready throughout SEND.
    foreach (beats1[k]) exp_q.push_back(beats1[k]);
    w_ready = 1'b0; r_ready = 1'b1; Res = 32'hDEADBEEF;
    pulse_start();
    for (int n = 0; n < 100 && !r_en; n++) begin
      w_ready = ~w_ready;
      tick();
    end
    r_ready = 1'b0; w_ready = 1'b1;
    check("t2_collect", {31'h0, r_en}, 32'h1);
    check("t2_beats_left", exp_q.size(), 32'd0);
    chk_rd("send_rready_c00", 0, 0, 8'h0A);
    chk_rd("send_rready_c33", 3, 3, 8'h34);
    capture(32'h51525354);
    capture(32'h61626364);
    capture(32'h71727374);
    capture(32'h81828384);
    check("t2_done", {31'h0, done}, 32'h1);
    chk_rd("t2_c33", 3, 3, 8'h84);
    chk_rd("t2_c01", 0, 1, 8'h61);
    tick();

    // Test 3: reset after beat 3 of SEND.
    for (int k = 0; k < 4; k++) exp_q.push_back(beats1[k]);
    w_ready = 1'b1;
    pulse_start();
    tick(); tick(); tick(); tick();
    w_reset = 1'b1;
    tick();
    w_reset = 1'b0;
    check("mid_rst_w_en", {31'h0, w_en}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_beats_left", exp_q.size(), 32'd0);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) chk_rd("mid_rst_rd", r, c, 8'h00);
    end

    // Test 4: fresh start with a same-cycle load, then a start during COLLECT.
    load(1'b1, 3, 3, 8'h55);
    foreach (beats4[k]) exp_q.push_back(beats4[k]);
    ld_en = 1'b1; ld_sel = 1'b0; ld_row = 2'd0; ld_col = 2'd0; ld_data = 8'h7F;
    pulse_start();
    ld_en = 1'b0;
    wait_r_en(50);
    check("t4_beats_left", exp_q.size(), 32'd0);
    pulse_start();
    check("collect_start_r_en", {31'h0, r_en}, 32'h1);
    check("collect_start_w_en", {31'h0, w_en}, 32'h0);
    capture(32'h01020304);
    capture(32'h05060708);
    capture(32'h090A0B0C);
    capture(32'h0D0E0F10);
    check("t4_done", {31'h0, done}, 32'h1);
    chk_rd("t4_c20", 2, 0, 8'h03);
    tick(); tick();
    check("final_beats_left", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
